accum_rr_scheduler: RTL and testbench
=====================================

// Module: accum_rr_scheduler
// PURPOSE
//   Shares one WIDTH-bit accumulate datapath (out <= out + 1 + step) between NUM_REQ requesters.
//   Each requester offers a step value with a valid/ready handshake.
//   A round-robin arbiter picks one requester per transaction, and a 3-state FSM sequences the update.
//   Sits above the counter datapath and replaces free-running per-cycle increments with
//   scheduled, attributed updates.
// PARAMETERS
//   NUM_REQ  4   number of requesters (>=2)
//   WIDTH    32  accumulator/output width
//   STEP_W   8   width of each requester's step field
// PORTS
//   CLK        in   1                clock; all state updates on posedge
//   RST        in   1                synchronous, active-low reset (sampled on posedge CLK)
//   en         in   1                scheduler enable; sampled only in IDLE
//   clr        in   1                synchronous clear of the accumulator
//   req_valid  in   NUM_REQ          per-requester request; bit i = requester i
//   req_step   in   NUM_REQ*STEP_W   step values; requester i owns bits [i*STEP_W +: STEP_W]
//   req_ready  out  NUM_REQ          one-hot handshake acknowledge
//   grant_id   out  $clog2(NUM_REQ)  index of the current/last granted requester
//   busy       out  1                high in GRANT and WRITE
//   out        out  WIDTH            accumulator value
//   out_valid  out  1                1-cycle pulse after each accumulator update
// BEHAVIOUR
//   Reset (RST==0 at posedge):
//     - state=IDLE; out=0, out_valid=0, req_ready=0, grant_id=0, busy=0, rr pointer=0.
//     - Reset overrides clr and any in-flight transaction; the pending step is dropped.
//   States: IDLE -> GRANT -> WRITE -> IDLE. No other transitions.
//   IDLE:
//     - If en=1 and |req_valid at posedge: winner = first set bit of req_valid, searching upward
//       from the rr pointer and wrapping modulo NUM_REQ.
//     - On that edge: grant_id<=winner, state<=GRANT. Otherwise stay in IDLE.
//   GRANT (exactly 1 cycle):
//     - req_ready = one-hot(grant_id), decoded from registered state/grant_id, not from req_valid.
//     - At the closing edge: step_reg <= req_step[grant_id]; state<=WRITE.
//     - Handshake completes on this edge. Requesters must hold valid and step stable from assertion
//       until they see ready.
//     - If valid drops early, it is a protocol violation: ready still pulses and the step is captured
//       anyway.
//   WRITE (exactly 1 cycle):
//     - Closing edge: out <= out + 1 + zero-extended step_reg, truncated modulo 2^WIDTH;
//       out_valid<=1 for the next cycle.
//     - Same edge: rr pointer <= (grant_id+1) mod NUM_REQ; state<=IDLE.
//   Latency: valid sampled at edge k -> ready high in cycle k..k+1 -> out updated at edge k+2.
//   Throughput: one update per 3 cycles max; a new arbitration may occur at edge k+3.
//   en=0: blocks new grants only; an in-flight GRANT/WRITE always completes.
//   clr=1 at any posedge:
//     - out<=0 and out_valid<=0; clr has priority over a coinciding WRITE update.
//     - The FSM and rr pointer advance normally; the step of a WRITE coinciding with clr is
//       discarded, and its handshake still counts as done.
//   Fairness: a requester holding valid is granted within NUM_REQ transactions.
//   grant_id holds its value outside GRANT/WRITE. out_valid=0 except the cycle after an update.
// TESTING
//   1. RST=0 for 2 cycles with all inputs toggling -> out=0, out_valid=0, req_ready=0, busy=0,
//      grant_id=0.
//   2. en=1, only req_valid[0], step0=5 -> req_ready=4'b0001 for 1 cycle; out=6 two edges after
//      sampling; out_valid pulses once.
//   3. All 4 valid held, steps=1 -> grant order 0,1,2,3,0; out=2,4,6,8,10; one update every
//      3 cycles.
//   4. WIDTH=8, out=0, step=8'hFF -> out=0 (0+1+255 wraps); out_valid still pulses.
//   5. clr=1 on the WRITE edge of a step=3 transaction -> out=0, no out_valid pulse; next grant
//      goes to the next requester in rr order.
//   6. RST=0 asserted during GRANT -> next cycle IDLE, out=0, req_ready=0, no out_valid;
//      rr pointer=0.

Source files
------------

// File: rtl/accum_rr_scheduler.sv
// accum_rr_scheduler
// Several requesters share one accumulate datapath: out <= out + 1 + step.
// A round-robin arbiter picks one requester per transaction. A three-state
// sequencer then runs IDLE -> GRANT -> WRITE -> IDLE, so at most one update
// happens every three cycles.
module accum_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int STEP_W  = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        en,
  input  logic                        clr,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*STEP_W-1:0]   req_step,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [STEP_W-1:0] step_reg;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [STEP_W-1:0] sel_step;
  logic [ID_W-1:0]   next_ptr;

  // Round-robin search: take the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Select the granted requester's step field. The index comes from the registered grant.
  always_comb begin
    sel_step = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        sel_step = req_step[k*STEP_W +: STEP_W];
      end
    end
  end

  // After the current grant, the pointer moves to the next requester. It wraps for non-power-of-two counts.
  always_comb begin
    next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Sequencer, arbiter bookkeeping and accumulator. Every output is registered here.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      step_reg  <= '0;
      grant_id  <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && found) begin
            grant_id  <= winner;
            req_ready <= NUM_REQ'(1) << winner;
            busy      <= 1'b1;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          step_reg  <= sel_step;
          req_ready <= '0;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          out       <= out + WIDTH'(1) + WIDTH'(step_reg);
          out_valid <= 1'b1;
          rr_ptr    <= next_ptr;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
      if (clr) begin
        out       <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accum_rr_scheduler.sv
// tb_accum_rr_scheduler
// Tests the round-robin accumulate scheduler against a behavioural model. The model
// holds the expected accumulator value and the round-robin pointer. A second, 8-bit
// instance is used to check wrap-around.
module tb_accum_rr_scheduler;

  logic        CLK;
  logic        RST;
  logic        en, clr;
  logic [3:0]  req_valid;
  logic [31:0] req_step;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic [31:0] out;
  logic        out_valid;

  logic        en8, clr8;
  logic [3:0]  req_valid8;
  logic [31:0] req_step8;
  logic [3:0]  req_ready8;
  logic [1:0]  grant_id8;
  logic        busy8;
  logic [7:0]  out8;
  logic        out_valid8;

  int          n_cmp;
  int          n_err;
  logic [31:0] m_out;
  logic [7:0]  m_out8;
  int          m_ptr;
  logic [7:0]  steps [4];

  accum_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .STEP_W(8)) dut (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr),
    .req_valid(req_valid), .req_step(req_step), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .out(out), .out_valid(out_valid)
  );

  accum_rr_scheduler #(.NUM_REQ(4), .WIDTH(8), .STEP_W(8)) dut8 (
    .CLK(CLK), .RST(RST), .en(en8), .clr(clr8),
    .req_valid(req_valid8), .req_step(req_step8), .req_ready(req_ready8),
    .grant_id(grant_id8), .busy(busy8), .out(out8), .out_valid(out_valid8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference arbiter: the first requester with valid set, searching upward from ptr and wrapping.
  function automatic int model_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pack_steps();
    return {steps[3], steps[2], steps[1], steps[0]};
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    for (int c = 0; c < 2; c++) begin
      en = 1'($urandom); clr = 1'($urandom);
      req_valid = 4'($urandom); req_step = $urandom;
      en8 = 1'($urandom); clr8 = 1'($urandom);
      req_valid8 = 4'($urandom); req_step8 = $urandom;
      tick();
    end
    n_cmp++; if (out !== 32'd0) begin n_err++; $display("[TB] FAIL reset_out: got %0h expected 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_cmp++; if (out8 !== 8'd0) begin n_err++; $display("[TB] FAIL reset_out8: got %0h expected 0", out8); end
    en = 1'b0; clr = 1'b0; req_valid = '0; req_step = '0;
    en8 = 1'b0; clr8 = 1'b0; req_valid8 = '0; req_step8 = '0;
    RST = 1'b1;
    m_out = '0; m_out8 = '0; m_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    steps = '{8'd5, 8'd0, 8'd0, 8'd0};
    req_step = pack_steps();
    en = 1'b1; req_valid = 4'b0001;
    tick();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL single_grant: got %0d expected 0", grant_id); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    req_valid = 4'b0000;
    tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL single_ready_pulse: got %b expected 0000", req_ready); end
    n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL single_out_early: got %0d expected %0d", out, m_out); end
    tick();
    m_out = m_out + 32'd1 + 32'(steps[0]);
    m_ptr = 1;
    n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL single_out: got %0d expected %0d", out, m_out); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL single_out_valid: got %b expected 1", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL single_out_valid_pulse: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int w;
    RST = 1'b0; tick(); RST = 1'b1;
    m_out = '0; m_out8 = '0; m_ptr = 0;
    steps = '{8'd1, 8'd1, 8'd1, 8'd1};
    req_step = pack_steps();
    en = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      w = model_pick(req_valid, m_ptr);
      tick();
      n_cmp++; if (grant_id !== 2'(w)) begin n_err++; $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", i, grant_id, w); end
      n_cmp++; if (req_ready !== 4'(1 << w)) begin n_err++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, 4'(1 << w)); end
      tick(2);
      m_out = m_out + 32'd1 + 32'(steps[w]);
      m_ptr = (w + 1) % 4;
      n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL rr_out[%0d]: got %0d expected %0d", i, out, m_out); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rr_out_valid[%0d]: got %b expected 1", i, out_valid); end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_enable();
    int w;
    en = 1'b0; req_valid = 4'b1111;
    tick(3);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL en_block_busy: got %b expected 0", busy); end
    n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL en_block_out: got %0d expected %0d", out, m_out); end
    en = 1'b1;
    w = model_pick(req_valid, m_ptr);
    tick();
    en = 1'b0;
    n_cmp++; if (grant_id !== 2'(w)) begin n_err++; $display("[TB] FAIL en_grant: got %0d expected %0d", grant_id, w); end
    tick(2);
    m_out = m_out + 32'd1 + 32'(steps[w]);
    m_ptr = (w + 1) % 4;
    n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL en_inflight_out: got %0d expected %0d", out, m_out); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL en_no_regrant: got %b expected 0", busy); end
    req_valid = 4'b0000;
    en = 1'b1;
  endtask

  task automatic test_wrap();
    logic [7:0] wsteps [3];
    wsteps = '{8'hFF, 8'h7F, 8'hFF};
    en8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_step8 = {24'd0, wsteps[i]};
      req_valid8 = 4'b0001;
      tick();
      n_cmp++; if (req_ready8 !== 4'b0001) begin n_err++; $display("[TB] FAIL wrap_ready[%0d]: got %b expected 0001", i, req_ready8); end
      req_valid8 = 4'b0000;
      tick(2);
      m_out8 = m_out8 + 8'd1 + wsteps[i];
      n_cmp++; if (out8 !== m_out8) begin n_err++; $display("[TB] FAIL wrap_out[%0d]: got %0h expected %0h", i, out8, m_out8); end
      n_cmp++; if (out_valid8 !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_out_valid[%0d]: got %b expected 1", i, out_valid8); end
    end
    en8 = 1'b0;
    tick();
  endtask

  task automatic test_clr();
    int w;
    steps = '{8'd3, 8'd3, 8'd3, 8'd3};
    req_step = pack_steps();
    en = 1'b1; req_valid = 4'b1111;
    w = model_pick(req_valid, m_ptr);
    tick();
    n_cmp++; if (grant_id !== 2'(w)) begin n_err++; $display("[TB] FAIL clr_grant: got %0d expected %0d", grant_id, w); end
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_out = '0;
    m_ptr = (w + 1) % 4;
    n_cmp++; if (out !== 32'd0) begin n_err++; $display("[TB] FAIL clr_out: got %0d expected 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL clr_out_valid: got %b expected 0", out_valid); end
    w = model_pick(req_valid, m_ptr);
    tick();
    n_cmp++; if (grant_id !== 2'(w)) begin n_err++; $display("[TB] FAIL clr_next_grant: got %0d expected %0d", grant_id, w); end
    tick(2);
    m_out = m_out + 32'd1 + 32'(steps[w]);
    m_ptr = (w + 1) % 4;
    n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL clr_after_out: got %0d expected %0d", out, m_out); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_in_grant();
    int w;
    en = 1'b1; req_valid = 4'b1111;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL rstg_busy_before: got %b expected 1", busy); end
    RST = 1'b0;
    tick();
    m_out = '0; m_out8 = '0; m_ptr = 0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstg_busy: got %b expected 0", busy); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL rstg_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (out !== 32'd0) begin n_err++; $display("[TB] FAIL rstg_out: got %0d expected 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstg_out_valid: got %b expected 0", out_valid); end
    RST = 1'b1;
    w = model_pick(req_valid, m_ptr);
    tick();
    n_cmp++; if (grant_id !== 2'(w)) begin n_err++; $display("[TB] FAIL rstg_ptr_grant: got %0d expected %0d", grant_id, w); end
    n_cmp++; if (req_ready !== 4'(1 << w)) begin n_err++; $display("[TB] FAIL rstg_ptr_ready: got %b expected %b", req_ready, 4'(1 << w)); end
    req_valid = 4'b0000;
    tick(2);
    m_out = m_out + 32'd1 + 32'(steps[w]);
    m_ptr = (w + 1) % 4;
    n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL rstg_out_after: got %0d expected %0d", out, m_out); end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [3:0] mask;
    logic en_r, do_clr;
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(0, 15));
      en_r = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) steps[k] = 8'($urandom);
      req_step = pack_steps();
      req_valid = mask; en = en_r;
      tick();
      if (en_r && mask != 4'b0) begin
        w = model_pick(mask, m_ptr);
        n_cmp++; if (grant_id !== 2'(w)) begin n_err++; $display("[TB] FAIL b2b_grant[%0d]: got %0d expected %0d", i, grant_id, w); end
        n_cmp++; if (req_ready !== 4'(1 << w)) begin n_err++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", i, req_ready, 4'(1 << w)); end
        if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
        en = 1'($urandom);
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_busy[%0d]: got %b expected 1", i, busy); end
        do_clr = ($urandom_range(0, 4) == 0);
        clr = do_clr;
        tick();
        clr = 1'b0;
        if (do_clr) m_out = '0;
        else m_out = m_out + 32'd1 + 32'(steps[w]);
        m_ptr = (w + 1) % 4;
        n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL b2b_out[%0d]: got %0h expected %0h", i, out, m_out); end
        n_cmp++; if (out_valid !== !do_clr) begin n_err++; $display("[TB] FAIL b2b_out_valid[%0d]: got %b expected %b", i, out_valid, !do_clr); end
      end else begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_idle_busy[%0d]: got %b expected 0", i, busy); end
        n_cmp++; if (out !== m_out) begin n_err++; $display("[TB] FAIL b2b_idle_out[%0d]: got %0h expected %0h", i, out, m_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_idle_out_valid[%0d]: got %b expected 0", i, out_valid); end
      end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    RST = 1'b0; en = 1'b0; clr = 1'b0; req_valid = '0; req_step = '0;
    en8 = 1'b0; clr8 = 1'b0; req_valid8 = '0; req_step8 = '0;
    m_out = '0; m_out8 = '0; m_ptr = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_enable();
    test_wrap();
    test_clr();
    test_reset_in_grant();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
